// File: rtl/cmd_arbiter.sv
// ----------------------------------------------------------------------------
// cmd_arbiter
//   Picks one command per slot from host read/write requests, an internally
//   generated periodic refresh and background scrub requests, and holds it in
//   a single registered output slot handed to the DFI command FSM through the
//   cmd_valid / fsm_ready handshake.
//
//   Optional feature macro: CMD_ARB_SCRUB_EN
//     defined   -> scrub source participates at lowest priority
//     undefined -> scrub_ready tied low, CMD_SCRUB never issued
//
// Parameters
//   TREFI        refresh interval in clk cycles (>= 2)
//   REF_PEND_MAX saturation value of the pending-refresh counter
//   REF_URGENT   pending count at which refresh preempts host traffic
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   host_valid/we/addr host request;  host_ready  = accepted this cycle
//   scrub_valid/addr   scrub request; scrub_ready = accepted this cycle
//   cmd_valid/type/addr output slot presented to the FSM
//   fsm_ready          FSM idle; transfer = cmd_valid & fsm_ready
//   ref_pending        outstanding refresh credits
//   ref_overflow       sticky: a refresh credit was lost at saturation
// ----------------------------------------------------------------------------
module cmd_arbiter #(
    parameter int unsigned TREFI        = 64,
    parameter int unsigned REF_PEND_MAX = 4,
    parameter int unsigned REF_URGENT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_valid,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    output logic        host_ready,
    input  logic        scrub_valid,
    input  logic [31:0] scrub_addr,
    output logic        scrub_ready,
    output logic        cmd_valid,
    output logic [2:0]  cmd_type,
    output logic [31:0] cmd_addr,
    input  logic        fsm_ready,
    output logic [2:0]  ref_pending,
    output logic        ref_overflow
);

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_READ    = 3'd1,
        CMD_WRITE   = 3'd2,
        CMD_REFRESH = 3'd3,
        CMD_SCRUB   = 3'd4
    } cmd_e;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_e;

    localparam int unsigned      TW      = $clog2(TREFI);
    localparam logic [TW-1:0]    TRELOAD = TW'(TREFI - 1);
    localparam logic [2:0]       URG     = 3'(REF_URGENT);
    localparam logic [2:0]       PMAX    = 3'(REF_PEND_MAX);

    slot_e          slot_q, slot_d;
    cmd_e           type_q, type_d;
    logic [31:0]    addr_q, addr_d;
    logic [2:0]     pend_q, pend_d;
    logic           ovf_q,  ovf_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic           urgent;
    logic           load;
    logic           tick;
    logic           ref_dec;
    logic           scrub_req;
    logic           win_valid;
    cmd_e           win_type;
    logic [31:0]    win_addr;

`ifdef CMD_ARB_SCRUB_EN
    assign scrub_req = scrub_valid;
`else
    logic unused_scrub;
    assign unused_scrub = ^{scrub_valid, scrub_addr};
    assign scrub_req    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= SLOT_EMPTY;
            type_q  <= CMD_NOP;
            addr_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            timer_q <= TRELOAD;
        end else begin
            slot_q  <= slot_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        urgent    = (pend_q >= URG);
        // A full slot only asserts cmd_valid, so fsm_ready alone marks a transfer.
        load      = (slot_q == SLOT_EMPTY) || fsm_ready;

        win_valid = 1'b1;
        win_type  = CMD_NOP;
        win_addr  = '0;
        if (urgent) begin
            win_type = CMD_REFRESH;
        end else if (host_valid) begin
            win_type = host_we ? CMD_WRITE : CMD_READ;
            win_addr = host_addr;
        end else if (pend_q != '0) begin
            win_type = CMD_REFRESH;
        end else if (scrub_req) begin
            win_type = CMD_SCRUB;
            win_addr = scrub_addr;
        end else begin
            win_valid = 1'b0;
        end

        slot_d = slot_q;
        type_d = type_q;
        addr_d = addr_q;
        if (load) begin
            slot_d = win_valid ? SLOT_FULL : SLOT_EMPTY;
            type_d = win_valid ? win_type  : CMD_NOP;
            addr_d = win_valid ? win_addr  : '0;
        end

        tick    = (timer_q == '0);
        timer_d = tick ? TRELOAD : timer_q - 1'b1;

        ref_dec = load && win_valid && (win_type == CMD_REFRESH);
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        if (tick && !ref_dec) begin
            if (pend_q == PMAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 3'd1;
            end
        end else if (!tick && ref_dec) begin
            pend_d = pend_q - 3'd1;
        end
    end

    // Readies are combinational from state, so gate them with the async reset
    // to keep them low for the whole time reset is asserted.
    assign host_ready = load && !urgent && !rst;
`ifdef CMD_ARB_SCRUB_EN
    assign scrub_ready = load && !host_valid && (pend_q == '0) && !rst;
`else
    assign scrub_ready = 1'b0;
`endif

    assign cmd_valid    = (slot_q == SLOT_FULL);
    assign cmd_type     = type_q;
    assign cmd_addr     = addr_q;
    assign ref_pending  = pend_q;
    assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cmd_arbiter
//   Scoreboard bench for cmd_arbiter. A cycle-level reference model computes
//   expected readies, slot occupancy and refresh credits from the arbitration
//   rules; every command the model places in the slot is queued, and a
//   separate monitor compares the DUT slot contents against the queue head,
//   popping on each transfer.
// ----------------------------------------------------------------------------
module tb_cmd_arbiter;

    localparam int TREFI = 64;
    localparam int PMAX  = 4;
    localparam int URG   = 3;
`ifdef CMD_ARB_SCRUB_EN
    localparam bit SCRUB_EN = 1'b1;
`else
    localparam bit SCRUB_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        host_valid;
    logic        host_we;
    logic [31:0] host_addr;
    logic        host_ready;
    logic        scrub_valid;
    logic [31:0] scrub_addr;
    logic        scrub_ready;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [31:0] cmd_addr;
    logic        fsm_ready;
    logic [2:0]  ref_pending;
    logic        ref_overflow;

    cmd_arbiter #(
        .TREFI        (TREFI),
        .REF_PEND_MAX (PMAX),
        .REF_URGENT   (URG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host_valid   (host_valid),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_ready   (host_ready),
        .scrub_valid  (scrub_valid),
        .scrub_addr   (scrub_addr),
        .scrub_ready  (scrub_ready),
        .cmd_valid    (cmd_valid),
        .cmd_type     (cmd_type),
        .cmd_addr     (cmd_addr),
        .fsm_ready    (fsm_ready),
        .ref_pending  (ref_pending),
        .ref_overflow (ref_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  t;
        logic [31:0] a;
    } item_t;

    item_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit m_full;
    bit m_ovf;
    int m_pend;
    int m_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cycle(input bit hv, input bit we, input logic [31:0] ha,
                         input bit sv, input logic [31:0] sa, input bit fr);
        bit    urgent, load, has, tick, dec, exp_hr, exp_sr;
        item_t w;
        int    np;
        host_valid  = hv;
        host_we     = we;
        host_addr   = ha;
        scrub_valid = sv;
        scrub_addr  = sa;
        fsm_ready   = fr;

        urgent = (m_pend >= URG);
        load   = !m_full || fr;
        exp_hr = load && !urgent;
        exp_sr = SCRUB_EN && load && !hv && (m_pend == 0);
        #3;
        chk("cmd_valid",    {31'b0, cmd_valid},    {31'b0, m_full});
        chk("ref_pending",  {29'b0, ref_pending},  m_pend);
        chk("ref_overflow", {31'b0, ref_overflow}, {31'b0, m_ovf});
        chk("host_ready",   {31'b0, host_ready},   {31'b0, exp_hr});
        chk("scrub_ready",  {31'b0, scrub_ready},  {31'b0, exp_sr});
        if (!m_full) begin
            chk("idle_type", {29'b0, cmd_type}, 32'd0);
            chk("idle_addr", cmd_addr, 32'd0);
        end

        has = 1'b1;
        if (urgent)                w = '{t: 3'd3, a: 32'd0};
        else if (hv)               w = '{t: (we ? 3'd2 : 3'd1), a: ha};
        else if (m_pend > 0)       w = '{t: 3'd3, a: 32'd0};
        else if (SCRUB_EN && sv)   w = '{t: 3'd4, a: sa};
        else begin
            has = 1'b0;
            w   = '0;
        end
        if (load) begin
            if (has) exp_q.push_back(w);
            m_full = has;
        end

        tick = ((m_cyc % TREFI) == TREFI - 1);
        dec  = load && has && (w.t == 3'd3);
        np   = m_pend + int'(tick) - int'(dec);
        if (np > PMAX) begin
            np    = PMAX;
            m_ovf = 1'b1;
        end
        m_pend = np;
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; asserts reset mid-cycle, checks outputs at once.
    task automatic do_reset();
        #1;
        rst         = 1'b1;
        host_valid  = 1'b0;
        scrub_valid = 1'b0;
        fsm_ready   = 1'b0;
        #1;
        chk("rst_cmd_valid",    {31'b0, cmd_valid},    32'd0);
        chk("rst_cmd_type",     {29'b0, cmd_type},     32'd0);
        chk("rst_cmd_addr",     cmd_addr,              32'd0);
        chk("rst_ref_pending",  {29'b0, ref_pending},  32'd0);
        chk("rst_ref_overflow", {31'b0, ref_overflow}, 32'd0);
        chk("rst_host_ready",   {31'b0, host_ready},   32'd0);
        chk("rst_scrub_ready",  {31'b0, scrub_ready},  32'd0);
        exp_q.delete();
        m_full = 1'b0;
        m_ovf  = 1'b0;
        m_pend = 0;
        m_cyc  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare slot contents with the scoreboard head; pop on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && cmd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("slot_unexpected", {31'b0, cmd_valid}, 32'd0);
                end else begin
                    chk("slot_type", {29'b0, cmd_type}, {29'b0, exp_q[0].t});
                    chk("slot_addr", cmd_addr, exp_q[0].a);
                    if (fsm_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        host_valid  = 1'b0;
        host_we     = 1'b0;
        host_addr   = '0;
        scrub_valid = 1'b0;
        scrub_addr  = '0;
        fsm_ready   = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // single host read, then drain
        cycle(1, 0, 32'h1234, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // slot held with WRITE 0xAA while FSM busy, host waiting
        cycle(1, 1, 32'hAA, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 32'hBB, 0, 0, 0);
        cycle(1, 0, 32'hBB, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // host idle: periodic refresh drains each credit
        for (int i = 0; i < 3 * TREFI; i++) cycle(0, 0, 0, 0, 0, 1);

        // FSM stalled, host pressing: saturate and overflow, then urgent refresh
        for (int i = 0; i < 5 * TREFI + 4; i++) cycle(1, 1, 32'hC0 + i, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(1, 0, 32'hD00 + i, 0, 0, 1);

        // scrub request with host idle and no pending refresh
        do_reset();
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 32'h55, 1);

        // reset while slot full and two refreshes pending
        do_reset();
        for (int i = 0; i < 2 * TREFI + 2; i++) cycle(1, 1, 32'hE0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < TREFI + 3; i++) cycle(0, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < 45, 1'($urandom), $urandom,
                      $urandom_range(0, 99) < 50, $urandom,
                      $urandom_range(0, 99) < 60);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
